// File: rtl/load_unit.sv
// Load unit: accepts one load at a time from the pipeline, issues one word
// read (or two for a misaligned load when SPLIT_EN=1), aligns and extends the
// result and returns it as a one-cycle response pulse.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req_valid/req_ready               request handshake
//   req_addr, req_fun3, req_rd        byte address, load type, destination tag
//   flush                             abort the load in flight (no response)
//   mem_req, mem_addr, mem_gnt        registered word-read request + grant
//   mem_rvalid, mem_rdata             read data return
//   rsp_valid, rsp_data, rsp_rd,      response pulse, result, tag, error flag
//   rsp_err
//   busy                              a load is in flight
module load_unit #(
    parameter int SPLIT_EN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_fun3,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] lo_q;
    logic [2:0]  fun3_q;
    logic        mis_q;
    logic        accept, bad_fun3, mis_in, err_in;
    logic [31:0] word_lo, word_hi, raw, result;

    assign req_ready = (state_q == IDLE) & ~flush;
    assign accept    = req_valid & req_ready;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP) & ~flush;

    assign bad_fun3 = (req_fun3 == 3'b011) | (req_fun3 == 3'b110) | (req_fun3 == 3'b111);
    // Halfwords only cross a word at offset 3; words at any nonzero offset.
    assign mis_in   = ((req_fun3[1:0] == 2'b01) & (req_addr[1:0] == 2'b11)) |
                      ((req_fun3 == 3'b010) & (req_addr[1:0] != 2'b00));
    assign err_in   = bad_fun3 | (mis_in & (SPLIT_EN == 0));

    // In WAIT0 the incoming word is the low word (high word is zero for an
    // unsplit load); in WAIT1 the incoming word is the high word.
    assign word_lo = (state_q == WAIT1) ? lo_q : mem_rdata;
    assign word_hi = (state_q == WAIT1) ? mem_rdata : 32'h0;
    assign raw     = 32'({word_hi, word_lo} >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (fun3_q)
            3'b000:  result = {{24{raw[7]}}, raw[7:0]};
            3'b001:  result = {{16{raw[15]}}, raw[15:0]};
            3'b100:  result = {24'h0, raw[7:0]};
            3'b101:  result = {16'h0, raw[15:0]};
            default: result = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = err_in ? RESP : REQ0;
            // A granted read still owes us data, so a flush must drain it.
            REQ0:  if (flush) state_d = mem_gnt ? DRAIN : IDLE;
                   else if (mem_gnt) state_d = WAIT0;
            WAIT0: if (mem_rvalid) state_d = flush ? IDLE : (mis_q ? REQ1 : RESP);
                   else if (flush) state_d = DRAIN;
            REQ1:  if (flush) state_d = mem_gnt ? DRAIN : IDLE;
                   else if (mem_gnt) state_d = WAIT1;
            WAIT1: if (mem_rvalid) state_d = flush ? IDLE : RESP;
                   else if (flush) state_d = DRAIN;
            RESP:  state_d = IDLE;
            DRAIN: if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            lo_q     <= 32'h0;
            fun3_q   <= 3'b000;
            mis_q    <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            rsp_data <= 32'h0;
            rsp_rd   <= 5'd0;
            rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_req <= (state_d == REQ0) | (state_d == REQ1);
            if (accept) begin
                addr_q <= req_addr;
                fun3_q <= req_fun3;
                rsp_rd <= req_rd;
                mis_q  <= mis_in;
            end
            if (state_q == IDLE && state_d == REQ0)
                mem_addr <= {req_addr[31:2], 2'b00};
            // Second word wraps naturally through the 30-bit word index.
            if (state_q == WAIT0 && state_d == REQ1)
                mem_addr <= {addr_q[31:2] + 30'd1, 2'b00};
            if (state_q == WAIT0 && mem_rvalid)
                lo_q <= mem_rdata;
            // Only the error path enters RESP straight from IDLE.
            rsp_err <= (state_q == IDLE) & (state_d == RESP);
            if (state_d == RESP)
                rsp_data <= (state_q == IDLE) ? 32'h0 : result;
        end
    end
endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;
    logic        clk = 1'b0;
    logic        reset_n, req_valid, req_valid0, flush, mem_gnt, mem_rvalid, zero;
    logic [31:0] req_addr, mem_rdata;
    logic [2:0]  req_fun3;
    logic [4:0]  req_rd;
    logic        req_ready, mem_req, rsp_valid, rsp_err, busy;
    logic [31:0] mem_addr, rsp_data;
    logic [4:0]  rsp_rd;
    logic        req_ready0, mem_req0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] mem_addr0, rsp_data0;
    logic [4:0]  rsp_rd0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_unit #(.SPLIT_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_fun3(req_fun3), .req_rd(req_rd), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err), .busy(busy));

    load_unit #(.SPLIT_EN(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_fun3(req_fun3), .req_rd(req_rd), .flush(flush),
        .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_gnt(zero),
        .mem_rvalid(zero), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid0),
        .rsp_data(rsp_data0), .rsp_rd(rsp_rd0), .rsp_err(rsp_err0), .busy(busy0));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Presents one load to dut, grants every request at once and returns data
    // one cycle after each grant (lo first, then hi). Latency counts cycles
    // after the acceptance edge; -1 means no response within the budget.
    task automatic run_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                            input logic [31:0] lo, input logic [31:0] hi,
                            output int lat, output logic [31:0] data, output logic err,
                            output logic [4:0] rdo, output int nreq,
                            output logic [31:0] a0, output logic [31:0] a1);
        int cyc, nresp;
        logic pend, pnext;
        lat = -1; data = 32'h0; err = 1'b0; rdo = 5'd0; nreq = 0; a0 = 32'h0; a1 = 32'h0;
        req_valid = 1'b1; req_addr = a; req_fun3 = f; req_rd = r;
        tick();
        req_valid = 1'b0;
        cyc = 1; nresp = 0; pend = 1'b0;
        while (cyc <= 20) begin
            mem_gnt    = mem_req;
            mem_rvalid = pend;
            mem_rdata  = pend ? ((nresp == 0) ? lo : hi) : 32'h0;
            if (mem_req) begin
                if (nreq == 0) a0 = mem_addr; else a1 = mem_addr;
                nreq++;
            end
            if (pend) nresp++;
            pnext = mem_req;
            #1;
            if (rsp_valid) begin
                lat = cyc; data = rsp_data; err = rsp_err; rdo = rsp_rd;
                break;
            end
            tick();
            pend = pnext;
            cyc++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({mem_req, rsp_valid, rsp_err, busy} !== 4'b0) begin failures++;
            $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, rsp_valid, rsp_err, busy}); end
        checks++; if ({mem_addr, rsp_data, rsp_rd} !== 69'h0) begin failures++;
            $display("FAIL reset_data: got %h/%h/%h expected zeros", mem_addr, rsp_data, rsp_rd); end
        tick();
        reset_n = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin failures++;
            $display("FAIL reset_ready: got %b expected 1", req_ready); end
        flush = 1'b1; #1;
        checks++; if (req_ready !== 1'b0) begin failures++;
            $display("FAIL flush_ready: got %b expected 0", req_ready); end
        flush = 1'b0;
        tick();
    endtask

    task automatic test_aligned();
        int lat, nreq; logic [31:0] d, a0, a1; logic e; logic [4:0] r;
        run_load(32'h100, 3'b010, 5'd3, 32'hDEADBEEF, 32'h0, lat, d, e, r, nreq, a0, a1);
        checks++; if (lat !== 3) begin failures++;
            $display("FAIL lw_latency: got %0d expected 3", lat); end
        checks++; if ({d, e, r} !== {32'hDEADBEEF, 1'b0, 5'd3}) begin failures++;
            $display("FAIL lw_data: got %h err %b rd %0d expected deadbeef 0 3", d, e, r); end
        checks++; if (nreq !== 1 || a0 !== 32'h100) begin failures++;
            $display("FAIL lw_reads: got %0d at %h expected 1 at 00000100", nreq, a0); end
    endtask

    task automatic test_subword();
        int lat, nreq; logic [31:0] d, a0, a1; logic e; logic [4:0] r;
        run_load(32'h103, 3'b000, 5'd1, 32'h80FF1234, 32'h0, lat, d, e, r, nreq, a0, a1);
        checks++; if (d !== 32'hFFFFFF80 || lat !== 3) begin failures++;
            $display("FAIL lb: got %h lat %0d expected ffffff80 lat 3", d, lat); end
        run_load(32'h103, 3'b100, 5'd2, 32'h80FF1234, 32'h0, lat, d, e, r, nreq, a0, a1);
        checks++; if (d !== 32'h00000080) begin failures++;
            $display("FAIL lbu: got %h expected 00000080", d); end
        run_load(32'h102, 3'b001, 5'd2, 32'h80FF1234, 32'h0, lat, d, e, r, nreq, a0, a1);
        checks++; if (d !== 32'hFFFF80FF) begin failures++;
            $display("FAIL lh: got %h expected ffff80ff", d); end
        run_load(32'h102, 3'b101, 5'd2, 32'h80FF1234, 32'h0, lat, d, e, r, nreq, a0, a1);
        checks++; if (d !== 32'h000080FF) begin failures++;
            $display("FAIL lhu: got %h expected 000080ff", d); end
    endtask

    task automatic test_split();
        int lat, nreq; logic [31:0] d, a0, a1; logic e; logic [4:0] r;
        run_load(32'h202, 3'b010, 5'd9, 32'h44332211, 32'h88776655, lat, d, e, r, nreq, a0, a1);
        checks++; if (lat !== 5 || d !== 32'h66554433 || e !== 1'b0) begin failures++;
            $display("FAIL split_lw: got %h lat %0d err %b expected 66554433 lat 5 err 0", d, lat, e); end
        checks++; if (nreq !== 2 || a0 !== 32'h200 || a1 !== 32'h204) begin failures++;
            $display("FAIL split_reads: got %0d %h %h expected 2 00000200 00000204", nreq, a0, a1); end
        // Same load into the non-splitting instance.
        req_addr = 32'h202; req_fun3 = 3'b010; req_rd = 5'd9; req_valid0 = 1'b1; #1;
        checks++; if (req_ready0 !== 1'b1) begin failures++;
            $display("FAIL nosplit_ready: got %b expected 1", req_ready0); end
        tick();
        req_valid0 = 1'b0; #1;
        checks++; if ({rsp_valid0, rsp_err0, rsp_data0, rsp_rd0} !== {1'b1, 1'b1, 32'h0, 5'd9}) begin failures++;
            $display("FAIL nosplit_err: got v%b e%b %h rd%0d expected v1 e1 00000000 rd9",
                     rsp_valid0, rsp_err0, rsp_data0, rsp_rd0); end
        checks++; if (mem_req0 !== 1'b0 || mem_addr0 !== 32'h0) begin failures++;
            $display("FAIL nosplit_mem: got %b %h expected 0 00000000", mem_req0, mem_addr0); end
        tick();
        checks++; if (rsp_valid0 !== 1'b0 || busy0 !== 1'b0) begin failures++;
            $display("FAIL nosplit_idle: got v%b busy%b expected 0 0", rsp_valid0, busy0); end
    endtask

    task automatic test_wrap_err();
        int lat, nreq; logic [31:0] d, a0, a1; logic e; logic [4:0] r;
        run_load(32'hFFFFFFFF, 3'b001, 5'd4, 32'h12345678, 32'h9ABCDEF0, lat, d, e, r, nreq, a0, a1);
        checks++; if (nreq !== 2 || a0 !== 32'hFFFFFFFC || a1 !== 32'h0) begin failures++;
            $display("FAIL wrap_reads: got %0d %h %h expected 2 fffffffc 00000000", nreq, a0, a1); end
        checks++; if (d !== 32'hFFFFF012 || lat !== 5) begin failures++;
            $display("FAIL wrap_data: got %h lat %0d expected fffff012 lat 5", d, lat); end
        run_load(32'h40, 3'b011, 5'd6, 32'h0, 32'h0, lat, d, e, r, nreq, a0, a1);
        checks++; if ({lat == 1, e, d, r} !== {1'b1, 1'b1, 32'h0, 5'd6} || nreq !== 0) begin failures++;
            $display("FAIL bad_fun3: got lat %0d err %b %h rd %0d reqs %0d expected 1 1 0 6 0",
                     lat, e, d, r, nreq); end
    endtask

    task automatic test_flush();
        // flush in WAIT0: drain the outstanding read, no response
        req_valid = 1'b1; req_addr = 32'h300; req_fun3 = 3'b010; req_rd = 5'd7;
        tick();
        req_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        checks++; if ({rsp_valid, busy, req_ready} !== 3'b010) begin failures++;
            $display("FAIL drain_state: got v%b busy%b rdy%b expected 0 1 0", rsp_valid, busy, req_ready); end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++;
            $display("FAIL drain_discard: got %b expected 0", rsp_valid); end
        tick();
        mem_rvalid = 1'b0; #1;
        checks++; if ({rsp_valid, busy, req_ready} !== 3'b001) begin failures++;
            $display("FAIL drain_exit: got v%b busy%b rdy%b expected 0 0 1", rsp_valid, busy, req_ready); end
        // flush in REQ0 without grant: back to IDLE, mem_req dropped
        req_valid = 1'b1; req_addr = 32'h310;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; #1;
        checks++; if ({mem_req, busy, rsp_valid} !== 3'b000) begin failures++;
            $display("FAIL flush_req0: got req%b busy%b v%b expected 0 0 0", mem_req, busy, rsp_valid); end
        // flush in RESP suppresses the pulse
        req_valid = 1'b1; req_fun3 = 3'b111;
        tick();
        req_valid = 1'b0; flush = 1'b1; #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++;
            $display("FAIL flush_resp: got v%b busy%b expected 0 1", rsp_valid, busy); end
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic test_gnt_stall();
        req_valid = 1'b1; req_addr = 32'h400; req_fun3 = 3'b010; req_rd = 5'd4;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = 1'b0; #1;
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin failures++;
                $display("FAIL stall_hold%0d: got %b %h expected 1 00000400", i, mem_req, mem_addr); end
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_rvalid = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFEF00D || rsp_rd !== 5'd4) begin failures++;
            $display("FAIL stall_rsp: got v%b %h rd%0d expected 1 cafef00d 4", rsp_valid, rsp_data, rsp_rd); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        req_valid = 1'b1; req_addr = 32'h502; req_fun3 = 3'b010; req_rd = 5'd5;
        tick();
        req_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        tick();
        mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h504) begin failures++;
            $display("FAIL mid_req1: got %b %h expected 1 00000504", mem_req, mem_addr); end
        tick();
        mem_gnt = 1'b0; reset_n = 1'b0; #1;
        checks++; if ({mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err, busy} !== 72'h0) begin failures++;
            $display("FAIL mid_reset: got req%b %h v%b %h rd%0d e%b busy%b expected all 0",
                     mem_req, mem_addr, rsp_valid, rsp_data, rsp_rd, rsp_err, busy); end
        tick();
        reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55667788;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rsp_valid || busy) seen = 1'b1;
            tick();
            mem_rvalid = 1'b0;
        end
        checks++; if (seen !== 1'b0) begin failures++;
            $display("FAIL mid_late_data: got activity %b expected 0", seen); end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; zero = 1'b0;
        req_addr = 32'h0; mem_rdata = 32'h0; req_fun3 = 3'b000; req_rd = 5'd0;
        test_reset();
        test_aligned();
        test_subword();
        test_split();
        test_wrap_err();
        test_flush();
        test_gnt_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 The block SHALL have one parameter: SPLIT_EN, default 1, where 1 means a misaligned load is split into two word reads and 0 means a misaligned load returns an error with no memory access.
REQ-002 The block SHALL have the following ports, in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  the pipeline presents a load request.
- req_ready  out  1  the block accepts the request this cycle.
- req_addr  in  32  byte address of the load.
- req_fun3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- req_rd  in  5  destination register tag.
- flush  in  1  abort the load in flight.
- mem_req  out  1  data-memory read request.
- mem_addr  out  32  word-aligned read address; bits [1:0] are always 00.
- mem_gnt  in  1  memory accepted mem_req this cycle.
- mem_rvalid  in  1  mem_rdata is valid this cycle.
- mem_rdata  in  32  read word.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  aligned, extended load result.
- rsp_rd  out  5  tag of the completed load.
- rsp_err  out  1  the response is an error.
- busy  out  1  state is not IDLE.

Function
REQ-003 The state machine SHALL use the states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP and DRAIN.
REQ-004 req_ready SHALL equal (state==IDLE) & ~flush; a request is accepted when req_valid & req_ready, and addr, fun3 and rd are latched at acceptance.
REQ-005 A load SHALL be misaligned when it is LH/LHU with addr[1:0]==11, or LW with addr[1:0]!=00.
REQ-006 On acceptance, the next state SHALL be:
- RESP with error set, when fun3 is 011, 110 or 111;
- RESP with error set, when the load is misaligned and SPLIT_EN==0;
- REQ0 otherwise.
REQ-007 REQ0 SHALL drive mem_req=1 and mem_addr={addr[31:2],2'b00}, and SHALL hold both until mem_gnt, then go to WAIT0.
REQ-008 WAIT0 SHALL capture mem_rdata as the low word on mem_rvalid, then go to REQ1 if the load is misaligned, else to RESP.
REQ-009 REQ1 SHALL drive mem_req=1 and mem_addr={addr[31:2]+1,2'b00}, wrapping modulo 2^32 (so 0xFFFFFFFF reads 0x00000000 second); on mem_gnt it SHALL go to WAIT1.
REQ-010 WAIT1 SHALL capture mem_rdata as the high word on mem_rvalid, then go to RESP.
REQ-011 Result computation:
- raw = ({hi,lo} >> 8*addr[1:0])[31:0], with hi=0 for an unsplit load;
- LB/LH sign-extend raw[7:0]/raw[15:0];
- LBU/LHU zero-extend raw[7:0]/raw[15:0];
- LW takes raw.
REQ-012 RESP SHALL assert rsp_valid=~flush for exactly one cycle, with rsp_data registered (0 when rsp_err=1) and rsp_rd equal to the latched rd, then go to IDLE.
REQ-013 mem_rvalid and mem_gnt SHALL be ignored in any state that does not expect them.
REQ-014 Minimum latency, with mem_gnt in the first REQ cycle and mem_rvalid one cycle later:
- aligned: rsp_valid 3 cycles after acceptance;
- split: rsp_valid 5 cycles after acceptance;
- error: rsp_valid 1 cycle after acceptance.
REQ-015 Flush behaviour:
- in IDLE or RESP: no request is accepted and no response is issued;
- in REQx without mem_gnt: go to IDLE and drop mem_req in the next cycle;
- in REQx with mem_gnt, or in WAITx without mem_rvalid: go to DRAIN;
- in WAITx with mem_rvalid: go to IDLE;
- in all cases no response is issued.
REQ-016 DRAIN SHALL wait for mem_rvalid, discard the data, and go to IDLE; flush has no further effect in DRAIN.
REQ-017 mem_req and mem_addr SHALL be registered outputs, stable while waiting for mem_gnt.

Reset
REQ-018 While reset_n=0:
- state SHALL be IDLE;
- mem_req, rsp_valid, rsp_err and busy SHALL be 0;
- mem_addr, rsp_data and rsp_rd SHALL be 0;
- req_ready SHALL be 1 once reset_n=1 and flush=0.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction immediately with no response; a memory response arriving after reset SHALL be ignored.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- LW at addr 0x100, mem_rdata=0xDEADBEEF -> one read at 0x100, rsp_data=0xDEADBEEF 3 cycles after acceptance.
- LB at 0x103 with word 0x80FF1234 -> rsp_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LW at 0x202, lo=0x44332211, hi=0x88776655 -> reads at 0x200 and then 0x204, rsp_data=0x66554433 after 5 cycles; with SPLIT_EN=0 -> rsp_err=1, rsp_data=0, no mem_req.
- LH at 0xFFFFFFFF -> second read at 0x00000000; fun3=011 -> error response 1 cycle after acceptance, no mem_req.
- flush during WAIT0 -> DRAIN, later mem_rvalid discarded, no rsp_valid, req_ready=1 the cycle after.
- mem_gnt held low for 4 cycles -> mem_req and mem_addr stable throughout; reset_n pulsed in WAIT1 -> all outputs 0 and no response.
